// File: rtl/ddr3_clk_rst_pkg.sv
// rtl/ddr3_clk_rst_pkg.sv - shared state encoding and defaults for the DDR3 clock/reset sequencer
package ddr3_clk_rst_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD     = 3'd0,
    ST_WAIT_CAL = 3'd1,
    ST_STAGGER  = 3'd2,
    ST_RUN      = 3'd3,
    ST_FAIL     = 3'd4
  } state_t;

  localparam int DEF_NUM_CH        = 2;
  localparam int DEF_HOLD_CYCLES   = 16;
  localparam int DEF_CALIB_TIMEOUT = 65536;
  localparam int DEF_MAX_RETRY     = 3;
  localparam int DEF_STAGGER       = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr3_bit_sync.sv
// rtl/ddr3_bit_sync.sv - parametrised-width two-flop synchronizer, sync active-low reset to 0
module ddr3_bit_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/ddr3_clk_rst_seq.sv
// rtl/ddr3_clk_rst_seq.sv - DDR3 MIG clock pass-through and per-channel reset/calibration sequencer
// Optional: DDR3_CALIB_SYNC_EN adds a 2-flop synchronizer on calib_done_i.
module ddr3_clk_rst_seq
  import ddr3_clk_rst_pkg::*;
#(
  parameter int C_NUM_CH        = DEF_NUM_CH,
  parameter int C_HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int C_CALIB_TIMEOUT = DEF_CALIB_TIMEOUT,
  parameter int C_MAX_RETRY     = DEF_MAX_RETRY,
  parameter int C_STAGGER       = DEF_STAGGER
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst_n,
  output logic                               sys_clk_i,
  output logic                               clk_ref_i,
  input  logic                               soft_rst_i,
  input  logic [C_NUM_CH-1:0]                calib_done_i,
  output logic [C_NUM_CH-1:0]                mig_rst_o,
  output logic [C_NUM_CH-1:0]                user_rst_n_o,
  output logic                               all_ready_o,
  output logic                               calib_fail_o,
  output logic [$clog2(C_MAX_RETRY+1)-1:0]   retry_cnt_o,
  output logic [STATE_W-1:0]                 state_o
);

  localparam int STG_SPAN = (C_NUM_CH > 1) ? (C_NUM_CH - 1) * C_STAGGER : 1;
  localparam int CNT_MAX  = max2(max2(C_HOLD_CYCLES, C_CALIB_TIMEOUT), STG_SPAN);
  localparam int CNT_W    = max2($clog2(CNT_MAX), 1);
  localparam int RTY_W    = $clog2(C_MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(C_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(C_CALIB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'(STG_SPAN - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(C_MAX_RETRY);

  assign sys_clk_i = sys_clk;
  assign clk_ref_i = sys_clk;

  logic [C_NUM_CH-1:0] calib_eff;

`ifdef DDR3_CALIB_SYNC_EN
  ddr3_bit_sync #(.W(C_NUM_CH)) u_calib_sync (
    .clk    (sys_clk),
    .resetn (sys_rst_n),
    .d      (calib_done_i),
    .q      (calib_eff)
  );
`else
  assign calib_eff = calib_done_i;
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RTY_W-1:0]    retry_q, retry_d;
  logic                all_done;
  logic [C_NUM_CH-1:0] mig_rst_d, user_rst_n_d;
  logic                ready_d, fail_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    retry_d  = retry_q;
    all_done = &calib_eff;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_CAL;
          cnt_d   = '0;
        end
      end
      ST_WAIT_CAL: begin
        // success beats a coincident timeout
        if (all_done) begin
          state_d = ST_STAGGER;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d = '0;
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_STAGGER: begin
        if (!all_done) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == STG_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!all_done) state_d = ST_HOLD;
      end
      ST_FAIL: cnt_d = '0;
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase

    if (soft_rst_i) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end

    // outputs are decoded from the next state so they come straight off flops
    mig_rst_d    = (state_d == ST_HOLD || state_d == ST_FAIL) ? '1 : '0;
    ready_d      = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAIL);
    user_rst_n_d = '0;
    for (int k = 0; k < C_NUM_CH; k++) begin
      if (state_d == ST_RUN)
        user_rst_n_d[k] = 1'b1;
      else if (state_d == ST_STAGGER)
        user_rst_n_d[k] = (int'(cnt_d) >= k * C_STAGGER);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= ST_HOLD;
      cnt_q        <= '0;
      retry_q      <= '0;
      mig_rst_o    <= '1;
      user_rst_n_o <= '0;
      all_ready_o  <= 1'b0;
      calib_fail_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      mig_rst_o    <= mig_rst_d;
      user_rst_n_o <= user_rst_n_d;
      all_ready_o  <= ready_d;
      calib_fail_o <= fail_d;
    end
  end

  assign retry_cnt_o = retry_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_ddr3_clk_rst_seq.sv
// tb/tb_ddr3_clk_rst_seq.sv - scoreboard bench for ddr3_clk_rst_seq (sync option off)
module tb_ddr3_clk_rst_seq;

  localparam int SEL_MIG = 0, SEL_USER = 1, SEL_READY = 2, SEL_FAIL = 3,
                 SEL_RETRY = 4, SEL_STATE = 5, SEL_CLKS = 6;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       sys_clk_i, clk_ref_i;
  logic       soft_rst_i;
  logic [1:0] calib_done_i;
  logic [1:0] mig_rst_o, user_rst_n_o;
  logic       all_ready_o, calib_fail_o;
  logic [1:0] retry_cnt_o;
  logic [2:0] state_o;

  ddr3_clk_rst_seq #(
    .C_NUM_CH(2), .C_HOLD_CYCLES(16), .C_CALIB_TIMEOUT(64),
    .C_MAX_RETRY(2), .C_STAGGER(4)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sys_clk_i(sys_clk_i),
    .clk_ref_i(clk_ref_i), .soft_rst_i(soft_rst_i), .calib_done_i(calib_done_i),
    .mig_rst_o(mig_rst_o), .user_rst_n_o(user_rst_n_o), .all_ready_o(all_ready_o),
    .calib_fail_o(calib_fail_o), .retry_cnt_o(retry_cnt_o), .state_o(state_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge sys_clk) begin
    if (!sys_rst_n) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      SEL_MIG:   return {6'd0, mig_rst_o};
      SEL_USER:  return {6'd0, user_rst_n_o};
      SEL_READY: return {7'd0, all_ready_o};
      SEL_FAIL:  return {7'd0, calib_fail_o};
      SEL_RETRY: return {6'd0, retry_cnt_o};
      SEL_STATE: return {5'd0, state_o};
      default:   return {6'd0, sys_clk_i, clk_ref_i};
    endcase
  endfunction

  exp_t       cur;
  logic [7:0] act;

  always @(negedge sys_clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      act = observe(cur.sel);
      checks++;
      if (cur.cyc != cyc || act !== cur.val) begin
        errors++;
        $display("FAIL %s @cycle %0d (checked at %0d): got %0h expected %0h",
                 cur.name, cur.cyc, cyc, act, cur.val);
      end
    end
  end

  task automatic expect_at(input int c, input int sel, input logic [7:0] v, input string n);
    exp_t e;
    e.cyc = c; e.sel = sel; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic expect_reset_vals(input int c);
    expect_at(c, SEL_MIG,   8'h3, "rst_mig");
    expect_at(c, SEL_USER,  8'h0, "rst_user");
    expect_at(c, SEL_READY, 8'h0, "rst_ready");
    expect_at(c, SEL_FAIL,  8'h0, "rst_fail");
    expect_at(c, SEL_RETRY, 8'h0, "rst_retry");
    expect_at(c, SEL_STATE, 8'h0, "rst_state");
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (sb.size() > 0 && t < 500) begin
      @(negedge sys_clk);
      t++;
    end
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s drain: %0d expectations left, expected 0", tag, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n    = 1'b0;
    soft_rst_i   = 1'b0;
    calib_done_i = 2'b00;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    // normal bring-up, then calibration loss in RUN and re-bring-up
    expect_reset_vals(0);
    expect_at(0,  SEL_CLKS,  8'h0, "clk_pass_low");
    expect_at(15, SEL_MIG,   8'h3, "s1_mig_hold_end");
    expect_at(16, SEL_MIG,   8'h0, "s1_mig_release");
    expect_at(16, SEL_STATE, 8'h1, "s1_wait_cal");
    expect_at(30, SEL_USER,  8'h0, "s1_user_pre");
    expect_at(31, SEL_USER,  8'h1, "s1_user0");
    expect_at(31, SEL_STATE, 8'h2, "s1_stagger");
    expect_at(31, SEL_READY, 8'h0, "s1_ready_pre");
    expect_at(34, SEL_USER,  8'h1, "s1_user1_pre");
    expect_at(35, SEL_USER,  8'h3, "s1_user1");
    expect_at(35, SEL_READY, 8'h1, "s1_ready");
    expect_at(35, SEL_STATE, 8'h3, "s1_run");
    expect_at(50, SEL_READY, 8'h1, "s3_ready_pre");
    expect_at(51, SEL_USER,  8'h0, "s3_user_loss");
    expect_at(51, SEL_READY, 8'h0, "s3_ready_loss");
    expect_at(51, SEL_MIG,   8'h3, "s3_mig_loss");
    expect_at(51, SEL_RETRY, 8'h0, "s3_retry_loss");
    expect_at(51, SEL_STATE, 8'h0, "s3_state_loss");
    expect_at(66, SEL_MIG,   8'h3, "s3_mig_hold_end");
    expect_at(67, SEL_MIG,   8'h0, "s3_mig_release");
    expect_at(68, SEL_USER,  8'h1, "s3_user0");
    expect_at(71, SEL_READY, 8'h0, "s3_ready_pre");
    expect_at(72, SEL_USER,  8'h3, "s3_user1");
    expect_at(72, SEL_READY, 8'h1, "s3_ready");
    wait_cyc(30); calib_done_i = 2'b11;
    wait_cyc(50); calib_done_i = 2'b01;
    wait_cyc(51); calib_done_i = 2'b11;
    drain("s1_s3");

    // retry exhaustion, then soft reset recovery
    pulse_reset();
    calib_done_i = 2'b00;
    expect_at(0,   SEL_STATE, 8'h0, "s2_state0");
    expect_at(79,  SEL_MIG,   8'h0, "s2_mig_pre1");
    expect_at(79,  SEL_RETRY, 8'h0, "s2_retry_pre1");
    expect_at(80,  SEL_MIG,   8'h3, "s2_mig_retry1");
    expect_at(80,  SEL_RETRY, 8'h1, "s2_retry1");
    expect_at(80,  SEL_STATE, 8'h0, "s2_hold1");
    expect_at(95,  SEL_MIG,   8'h3, "s2_mig_hold1_end");
    expect_at(96,  SEL_MIG,   8'h0, "s2_mig_rel1");
    expect_at(159, SEL_RETRY, 8'h1, "s2_retry_pre2");
    expect_at(160, SEL_MIG,   8'h3, "s2_mig_retry2");
    expect_at(160, SEL_RETRY, 8'h2, "s2_retry2");
    expect_at(239, SEL_STATE, 8'h1, "s2_last_wait");
    expect_at(239, SEL_FAIL,  8'h0, "s2_fail_pre");
    expect_at(240, SEL_STATE, 8'h4, "s2_fail_state");
    expect_at(240, SEL_FAIL,  8'h1, "s2_fail");
    expect_at(240, SEL_MIG,   8'h3, "s2_fail_mig");
    expect_at(240, SEL_USER,  8'h0, "s2_fail_user");
    expect_at(255, SEL_FAIL,  8'h1, "s2_fail_sticky");
    expect_at(255, SEL_MIG,   8'h3, "s2_fail_mig_sticky");
    drain("s2");

    expect_at(260, SEL_FAIL,  8'h1, "s4_fail_pre");
    expect_at(261, SEL_STATE, 8'h0, "s4_state_hold");
    expect_at(261, SEL_RETRY, 8'h0, "s4_retry_clr");
    expect_at(261, SEL_FAIL,  8'h0, "s4_fail_clr");
    expect_at(261, SEL_MIG,   8'h3, "s4_mig_hold");
    expect_at(276, SEL_MIG,   8'h3, "s4_mig_hold_end");
    expect_at(277, SEL_STATE, 8'h1, "s4_wait_cal");
    expect_at(278, SEL_USER,  8'h1, "s4_user0");
    expect_at(281, SEL_READY, 8'h0, "s4_ready_pre");
    expect_at(282, SEL_READY, 8'h1, "s4_ready");
    expect_at(282, SEL_USER,  8'h3, "s4_user1");
    wait_cyc(260); soft_rst_i = 1'b1; calib_done_i = 2'b11;
    wait_cyc(261); soft_rst_i = 1'b0;
    drain("s4");

    // tie-break at timeout, then reset during STAGGER
    pulse_reset();
    calib_done_i = 2'b00;
    expect_at(78, SEL_STATE, 8'h1, "s5_wait_pre");
    expect_at(79, SEL_STATE, 8'h1, "s5_wait_last");
    expect_at(79, SEL_RETRY, 8'h0, "s5_retry_pre");
    expect_at(80, SEL_STATE, 8'h2, "s5_stagger");
    expect_at(80, SEL_RETRY, 8'h0, "s5_retry_kept");
    expect_at(80, SEL_USER,  8'h1, "s5_user0");
    expect_at(80, SEL_MIG,   8'h0, "s5_mig");
    expect_at(81, SEL_USER,  8'h1, "s6_user_pre");
    wait_cyc(79); calib_done_i = 2'b11;
    wait_cyc(81);
    @(negedge sys_clk);
    #1;
    drain("s5");

    pulse_reset();
    expect_reset_vals(0);
    expect_at(1, SEL_STATE, 8'h0, "s6_state_c1");
    expect_at(1, SEL_MIG,   8'h3, "s6_mig_c1");
    drain("s6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
